fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_if.sv | 31 +++
 rtl/fetch.sv | 101 ++++++++++
 tb/tb_fetch.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage port bundle: decode control, instruction-memory channel, decode output.
// Latency: n/a (wires only).
// Backpressure: i_stall from decode; o_imem_req is withheld by fetch when no queue credit remains.
// Ports (fetch side, modport slave):
//   i_stall, i_pcsrc, i_nextPC         decode hold / redirect select / redirect target
//   o_imem_req, o_imem_addr, i_imem_gnt request channel (accepted on req && gnt)
//   i_imem_rvalid, i_imem_rdata        in-order read responses
//   o_valid, o_instr, o_pc_plus4       instruction presented to decode
interface fetch_if;
  logic        i_stall;
  logic [1:0]  i_pcsrc;
  logic [31:0] i_nextPC;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc_plus4;

  modport slave (
    input  i_stall, i_pcsrc, i_nextPC, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    output o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_plus4
  );

  modport master (
    output i_stall, i_pcsrc, i_nextPC, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    input  o_imem_req, o_imem_addr, o_valid, o_instr, o_pc_plus4
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: issues word requests, queues in-order responses (2 entries) for decode.
// Latency: response written at the edge it arrives, visible on o_valid the next cycle.
// Backpressure: i_stall holds the queue head; requests issue only while outstanding+occupancy-pop < 2.
// Ports: i_clk, i_rst (synchronous, active-high), bus (fetch_if.slave).
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic    i_clk,
  input logic    i_rst,
  fetch_if.slave bus
);

  logic [31:0] pc;          // address of the next request to issue
  logic [31:0] resp_pc;     // address of the next response that will be kept
  logic [31:0] q_instr [2];
  logic [31:0] q_pc4   [2];
  logic        rd_ptr;
  logic [1:0]  count;       // queue occupancy 0..2
  logic [1:0]  outstanding; // accepted requests not yet answered, kept or dropped
  logic [1:0]  drop;        // responses still owed to a flushed stream

  logic       redirect;
  logic       valid;
  logic       pop;
  logic       req;
  logic       acc;
  logic       rv;
  logic       discard;
  logic       push;
  logic       wr_ptr;
  logic [2:0] committed;
  logic [2:0] out_next;

  always_comb begin
    redirect  = (bus.i_pcsrc != 2'b00);
    valid     = (count != 2'd0);
    // The redirecting instruction is always consumed, even under stall.
    pop       = valid && (redirect || !bus.i_stall);
    // Queue slots already spoken for. Counting dropped-but-outstanding
    // responses is conservative, and because a pop shrinks count at the same
    // edge, a raised but ungranted request can never lose its credit.
    committed = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};
    req       = !i_rst && (committed < 3'd2);
    acc       = req && bus.i_imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    rv        = bus.i_imem_rvalid && (outstanding != 2'd0);
    discard   = rv && (redirect || (drop != 2'd0));
    push      = rv && !discard;
    // count==2 wraps the tail onto the head slot; only legal together with a pop.
    wr_ptr    = rd_ptr ^ count[0];
    out_next  = {1'b0, outstanding} + {2'b00, acc} - {2'b00, rv};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      q_instr[0]  <= '0;
      q_instr[1]  <= '0;
      q_pc4[0]    <= '0;
      q_pc4[1]    <= '0;
    end else begin
      outstanding <= out_next[1:0];
      if (redirect) begin
        // Everything still in flight, including a request granted this
        // cycle, belongs to the old stream.
        pc      <= bus.i_nextPC;
        resp_pc <= bus.i_nextPC;
        count   <= 2'd0;
        drop    <= out_next[1:0];
      end else begin
        if (acc) begin
          pc <= pc + 32'd4;
        end
        if (discard) begin
          drop <= drop - 2'd1;
        end
        if (push) begin
          q_instr[wr_ptr] <= bus.i_imem_rdata;
          q_pc4[wr_ptr]   <= resp_pc + 32'd4;
          resp_pc         <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = pc;
  assign bus.o_valid     = valid;
  assign bus.o_instr     = q_instr[rd_ptr];
  assign bus.o_pc_plus4  = q_pc4[rd_ptr];

endmodule

// File: tb/tb_fetch.sv
// Testbench for fetch: directed scenarios plus randomized memory/decode traffic.
// Latency: one DUT cycle per call of run_cycle.
// Backpressure: random grant, response latency, stall and redirect are all exercised.
module tb_fetch;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch #(.RESET_PC(RST_PC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } pend_t;

  pend_t       pend[$];   // accepted requests awaiting a memory response
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          occ    = 0;  // instructions of the live stream delivered but not yet consumed
  int          epoch  = 0;  // bumps on every redirect; older responses are stale
  int          n_dec  = 0;
  logic [31:0] exp_pc;      // next PC decode should receive
  logic [31:0] req_pc;      // next address fetch should request
  logic [31:0] prev_addr;
  bit          prev_wait = 1'b0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.i_stall = 1'b0;
    bus.i_pcsrc = 2'b00;
    bus.i_nextPC = 32'h0;
    bus.i_imem_gnt = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata = 32'h0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_req", 32'(bus.o_imem_req), 32'h0);
    chk("rst_instr", bus.o_instr, 32'h0);
    chk("rst_pc_plus4", bus.o_pc_plus4, 32'h0);
    chk("rst_addr", bus.o_imem_addr, RST_PC);
    pend.delete();
    occ = 0;
    exp_pc = RST_PC;
    req_pc = RST_PC;
    prev_wait = 1'b0;
    rst = 1'b0;
  endtask

  // One clock cycle; entered and left at posedge+1.
  // gmode: 0 always grant, 1 random grant, 2 never grant.
  task automatic run_cycle(input bit rnd, input bit stall_in, input logic [1:0] pcsrc_in,
                           input logic [31:0] npc_in, input int gmode,
                           input int lat_min, input int lat_max);
    bit          rv, g, redir, pop, keep;
    logic        stall_v;
    logic [1:0]  pcsrc_v;
    logic [31:0] npc_v;
    pend_t       h;
    rv = (pend.size() != 0) && (pend[0].due <= cyc);
    if (rv) bus.i_imem_rdata = mem_word(pend[0].addr);
    else bus.i_imem_rdata = $urandom;
    // occasional spurious response with nothing outstanding
    if (rnd && pend.size() == 0 && $urandom_range(0, 19) == 0) bus.i_imem_rvalid = 1'b1;
    else bus.i_imem_rvalid = rv;
    if (rnd) begin
      stall_v = ($urandom_range(0, 3) == 0);
      if (bus.o_valid && $urandom_range(0, 11) == 0) begin
        pcsrc_v = 2'($urandom_range(1, 3));
        npc_v = $urandom & 32'hFFFF_FFFC;
      end else begin
        pcsrc_v = 2'b00;
        npc_v = $urandom;
      end
    end else begin
      stall_v = stall_in;
      pcsrc_v = pcsrc_in;
      npc_v = npc_in;
    end
    bus.i_stall = stall_v;
    bus.i_pcsrc = pcsrc_v;
    bus.i_nextPC = npc_v;
    #1;
    s_req = bus.o_imem_req;
    s_addr = bus.o_imem_addr;
    s_valid = bus.o_valid;
    s_instr = bus.o_instr;
    s_pc4 = bus.o_pc_plus4;
    case (gmode)
      0: g = 1'b1;
      1: g = ($urandom_range(0, 2) != 0);
      default: g = 1'b0;
    endcase
    g = g && s_req;
    bus.i_imem_gnt = g;
    #1;
    redir = (pcsrc_v != 2'b00);
    pop = s_valid && (redir || !stall_v);
    chk("valid_vs_model", 32'(s_valid), 32'(occ != 0));
    if (s_req) chk("credit", 32'((pend.size() + occ - int'(pop)) < 2), 32'h1);
    if (prev_wait) begin
      chk("req_hold", 32'(s_req), 32'h1);
      chk("addr_hold", s_addr, prev_addr);
    end
    if (pop) begin
      chk("instr", s_instr, mem_word(exp_pc));
      chk("pc_plus4", s_pc4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      n_dec++;
    end
    keep = 1'b0;
    if (rv) begin
      h = pend.pop_front();
      keep = !redir && (h.epoch == epoch);
    end
    if (g) begin
      chk("req_addr", s_addr, req_pc);
      req_pc = req_pc + 32'd4;
      pend.push_back('{addr: s_addr, due: cyc + $urandom_range(lat_min, lat_max), epoch: epoch});
    end
    occ = occ - int'(pop) + int'(keep);
    if (redir) begin
      occ = 0;
      exp_pc = npc_v;
      req_pc = npc_v;
      epoch++;
    end
    if (occ > 2) chk("queue_overflow", 32'(occ), 32'h2);
    prev_wait = s_req && !g && !redir;
    prev_addr = s_addr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          cnt;
    bit          seen;
    logic [31:0] held;
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);

    // reset release, 1-cycle memory
    run_cycle(0, 0, 2'b00, 32'h0, 0, 1, 1);
    chk("first_req", 32'(s_req), 32'h1);
    chk("first_addr", s_addr, 32'h0040_0000);
    chk("first_valid", 32'(s_valid), 32'h0);
    run_cycle(0, 0, 2'b00, 32'h0, 0, 1, 1);
    chk("second_addr", s_addr, 32'h0040_0004);
    chk("second_valid", 32'(s_valid), 32'h0);
    run_cycle(0, 0, 2'b00, 32'h0, 0, 1, 1);
    chk("valid_after_2", 32'(s_valid), 32'h1);
    chk("first_pc_plus4", s_pc4, 32'h0040_0004);

    // sustained throughput
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle(0, 0, 2'b00, 32'h0, 0, 1, 1);
      if (s_valid) cnt++;
    end
    chk("throughput", 32'(cnt), 32'd20);

    // stall held 4 cycles
    held = bus.o_instr;
    for (int i = 0; i < 4; i++) begin
      run_cycle(0, 1, 2'b00, 32'h0, 0, 1, 1);
      chk("stall_instr_const", s_instr, held);
    end
    chk("stall_req_low", 32'(s_req), 32'h0);
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 2'b00, 32'h0, 0, 1, 1);

    // redirect with two responses outstanding
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (pend.size() == 2) seen = 1'b1;
      else run_cycle(0, 0, 2'b00, 32'h0, 0, 2, 2);
    end
    chk("setup_two_outstanding", 32'(seen), 32'h1);
    run_cycle(0, 0, 2'b01, 32'h0000_1000, 0, 2, 2);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      run_cycle(0, 0, 2'b00, 32'h0, 0, 2, 2);
      if (s_valid) begin
        seen = 1'b1;
        chk("redirect_pc_plus4", s_pc4, 32'h0000_1004);
      end
    end
    chk("redirect_word_seen", 32'(seen), 32'h1);

    // ungranted request pending at redirect
    do_reset(1);
    run_cycle(0, 0, 2'b00, 32'h0, 2, 1, 1);
    chk("ungranted_req", 32'(s_req), 32'h1);
    run_cycle(0, 0, 2'b10, 32'h0000_2000, 2, 1, 1);
    run_cycle(0, 0, 2'b00, 32'h0, 0, 1, 1);
    chk("redirect_addr_switch", s_addr, 32'h0000_2000);
    chk("redirect_req_next", 32'(s_req), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      run_cycle(0, 0, 2'b00, 32'h0, 0, 1, 1);
      if (s_valid) begin
        seen = 1'b1;
        chk("no_stale_pc_plus4", s_pc4, 32'h0000_2004);
      end
    end
    chk("target_word_seen", 32'(seen), 32'h1);

    // PC wrap at the top of the address space
    run_cycle(0, 0, 2'b11, 32'hFFFF_FFF8, 0, 1, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run_cycle(0, 0, 2'b00, 32'h0, 0, 1, 1);
      if (s_valid && s_pc4 == 32'h0) seen = 1'b1;
    end
    chk("wrap_pc_plus4_zero", 32'(seen), 32'h1);

    // randomized traffic with a mid-run reset
    cnt = n_dec;
    for (int i = 0; i < 1500; i++) run_cycle(1, 0, 2'b00, 32'h0, 1, 1, 3);
    do_reset(1);
    for (int i = 0; i < 1500; i++) run_cycle(1, 0, 2'b00, 32'h0, 1, 1, 3);
    chk("random_progress", 32'((n_dec - cnt) > 200), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
